// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter over 16 sticky request lines with a one-hot grant,
// a ready/valid handshake, a post-grant hold window and a saturating drop counter.
module rr_onehot_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant_onehot,
    output logic        grant_valid,
    input  logic        grant_ready,
    output logic        enc_enable,
    output logic [15:0] pending,
    output logic [7:0]  drop_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [7:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    logic [1:0]  state;
    logic [15:0] req_q;
    logic [3:0]  ptr;
    logic [3:0]  grant_idx;
    logic [7:0]  hold_cnt;

    logic [15:0] edge_bits;
    logic        accept;
    logic [15:0] clear_mask;
    logic [15:0] drop_bits;
    logic [4:0]  drop_num;
    logic [8:0]  drop_sum;
    logic [3:0]  sel_idx;
    logic [3:0]  scan_idx;
    logic        sel_found;

    assign edge_bits  = req & ~req_q;
    assign accept     = (state == ST_OFFER) && grant_ready;
    assign clear_mask = accept ? grant_onehot : 16'h0000;
    // A coincident edge beats the clear, so only edges on bits that stay pending are lost.
    assign drop_bits  = edge_bits & pending & ~clear_mask;
    assign drop_sum   = {1'b0, drop_cnt} + 9'(drop_num);

    assign grant_valid = (state == ST_OFFER);
    assign enc_enable  = grant_valid;

    // NOTE: every variable written here gets a default first, otherwise synthesis infers latches.
    always_comb begin
        drop_num = 5'd0;
        for (int i = 0; i < 16; i++) begin
            drop_num = drop_num + 5'(drop_bits[i]);
        end
    end

    // Search upward from ptr with 4-bit wraparound; first hit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        scan_idx  = ptr;
        for (int i = 0; i < 16; i++) begin
            scan_idx = ptr + 4'(i);
            if (!sel_found && pending[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_q        <= 16'h0000;
            pending      <= 16'h0000;
            ptr          <= 4'd0;
            grant_idx    <= 4'd0;
            grant_onehot <= 16'h0000;
            hold_cnt     <= 8'd0;
            drop_cnt     <= 8'd0;
        end else begin
            req_q    <= req;
            pending  <= (pending & ~clear_mask) | edge_bits;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_onehot <= 16'h0001 << sel_idx;
                        grant_idx    <= sel_idx;
                        state        <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (grant_ready) begin
                        grant_onehot <= 16'h0000;
                        ptr          <= grant_idx + 4'd1;
                        hold_cnt     <= HOLD_LAST;
                        state        <= (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    grant_onehot <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed self-checking bench for rr_onehot_arbiter (HOLD_CYCLES = 4).
module tb_rr_onehot_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] req;
    logic [15:0] grant_onehot;
    logic        grant_valid;
    logic        grant_ready;
    logic        enc_enable;
    logic [15:0] pending;
    logic [7:0]  drop_cnt;

    int n_cmp;
    int n_bad;

    rr_onehot_arbiter #(.HOLD_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .enc_enable   (enc_enable),
        .pending      (pending),
        .drop_cnt     (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Structural invariants sampled on the falling edge.
    always @(negedge clock) begin
        n_cmp++;
        if ($countones(grant_onehot) > 1 || enc_enable !== grant_valid ||
            grant_valid !== (grant_onehot != 16'h0000)) begin
            n_bad++;
            $display("FAIL invariant: grant_onehot=%h grant_valid=%b enc_enable=%b", grant_onehot,
                     grant_valid, enc_enable);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_gv(input int max_cycles, input string name);
        int n;
        n = 0;
        while (grant_valid !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        if (grant_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: grant_valid not seen within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic test_reset();
        req = 16'h0000;
        grant_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (grant_onehot !== 16'h0000 || grant_valid !== 1'b0 || enc_enable !== 1'b0 ||
            pending !== 16'h0000 || drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state: grant=%h gv=%b en=%b pend=%h drop=%0d, want all 0",
                     grant_onehot, grant_valid, enc_enable, pending, drop_cnt);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (pending !== 16'h0000 || grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: pend=%h gv=%b, want 0000/0", pending, grant_valid);
        end
    endtask

    task automatic test_single();
        req = 16'h0000;
        grant_ready = 1'b1;
        apply_reset();
        req = 16'h0020;
        step();
        n_cmp++;
        if (pending !== 16'h0020 || grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pend: pend=%h gv=%b, want 0020/0", pending, grant_valid);
        end
        step();
        n_cmp++;
        if (grant_onehot !== 16'h0020 || grant_valid !== 1'b1 || enc_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: grant=%h gv=%b en=%b, want 0020/1/1", grant_onehot,
                     grant_valid, enc_enable);
        end
        step();
        n_cmp++;
        if (grant_onehot !== 16'h0000 || grant_valid !== 1'b0 || pending !== 16'h0000) begin
            n_bad++;
            $display("FAIL single_accept: grant=%h gv=%b pend=%h, want 0000/0/0000", grant_onehot,
                     grant_valid, pending);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (grant_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL single_hold[%0d]: gv=%b, want 0", i, grant_valid);
            end
        end
        req = 16'h0000;
    endtask

    task automatic test_round_robin();
        req = 16'h0000;
        grant_ready = 1'b1;
        apply_reset();
        req = 16'h8001;
        step();
        req = 16'h0000;
        step();
        n_cmp++;
        if (grant_onehot !== 16'h0001 || grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_first: grant=%h gv=%b, want 0001/1", grant_onehot, grant_valid);
        end
        step();
        wait_gv(20, "rr_second_wait");
        n_cmp++;
        if (grant_onehot !== 16'h8000) begin
            n_bad++;
            $display("FAIL rr_second: grant=%h, want 8000", grant_onehot);
        end
        step();
        req = 16'h0001;
        step();
        req = 16'h0000;
        wait_gv(20, "rr_wrap_wait");
        n_cmp++;
        if (grant_onehot !== 16'h0001) begin
            n_bad++;
            $display("FAIL rr_wrap: grant=%h, want 0001", grant_onehot);
        end
        step();
    endtask

    task automatic test_backpressure();
        req = 16'h0000;
        grant_ready = 1'b0;
        apply_reset();
        req = 16'h0100;
        step();
        req = 16'h0000;
        step();
        req = 16'h0004;
        for (int i = 0; i < 10; i++) begin
            step();
            req = 16'h0000;
            n_cmp++;
            if (grant_onehot !== 16'h0100 || grant_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_stable[%0d]: grant=%h gv=%b, want 0100/1", i, grant_onehot,
                         grant_valid);
            end
        end
        n_cmp++;
        if (pending !== 16'h0104) begin
            n_bad++;
            $display("FAIL bp_pending: pend=%h, want 0104", pending);
        end
        grant_ready = 1'b1;
        step();
        n_cmp++;
        if (grant_valid !== 1'b0 || pending !== 16'h0004) begin
            n_bad++;
            $display("FAIL bp_accept: gv=%b pend=%h, want 0/0004", grant_valid, pending);
        end
        wait_gv(20, "bp_next_wait");
        n_cmp++;
        if (grant_onehot !== 16'h0004) begin
            n_bad++;
            $display("FAIL bp_next: grant=%h, want 0004", grant_onehot);
        end
        step();
        grant_ready = 1'b0;
    endtask

    task automatic test_multi_drop();
        req = 16'h0000;
        grant_ready = 1'b0;
        apply_reset();
        req = 16'h000F;
        step();
        req = 16'h0000;
        step();
        n_cmp++;
        if (drop_cnt !== 8'd0 || grant_onehot !== 16'h0001) begin
            n_bad++;
            $display("FAIL mdrop_first: drop=%0d grant=%h, want 0/0001", drop_cnt, grant_onehot);
        end
        req = 16'h000F;
        step();
        req = 16'h0000;
        n_cmp++;
        if (drop_cnt !== 8'd4) begin
            n_bad++;
            $display("FAIL mdrop_sum: drop=%0d, want 4", drop_cnt);
        end
    endtask

    task automatic test_drop_saturate();
        req = 16'h0000;
        grant_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            req = 16'h0008;
            step();
            req = 16'h0000;
            step();
            if (i == 9) begin
                n_cmp++;
                if (drop_cnt !== 8'd9) begin
                    n_bad++;
                    $display("FAIL drop_mid: drop=%0d, want 9", drop_cnt);
                end
            end
        end
        n_cmp++;
        if (drop_cnt !== 8'd255 || pending[3] !== 1'b1 || grant_onehot !== 16'h0008) begin
            n_bad++;
            $display("FAIL drop_sat: drop=%0d pend3=%b grant=%h, want 255/1/0008", drop_cnt,
                     pending[3], grant_onehot);
        end
    endtask

    task automatic test_set_wins();
        req = 16'h0000;
        grant_ready = 1'b0;
        apply_reset();
        req = 16'h0080;
        step();
        req = 16'h0000;
        step();
        n_cmp++;
        if (grant_onehot !== 16'h0080 || grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_grant: grant=%h gv=%b, want 0080/1", grant_onehot, grant_valid);
        end
        req = 16'h0080;
        grant_ready = 1'b1;
        step();
        req = 16'h0000;
        n_cmp++;
        if (pending !== 16'h0080 || drop_cnt !== 8'd0 || grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_accept: pend=%h drop=%0d gv=%b, want 0080/0/0", pending, drop_cnt,
                     grant_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (grant_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL sw_hold[%0d]: gv=%b, want 0", i, grant_valid);
            end
        end
        step();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_onehot !== 16'h0080) begin
            n_bad++;
            $display("FAIL sw_regrant: gv=%b grant=%h, want 1/0080", grant_valid, grant_onehot);
        end
        grant_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        req = 16'hFFFF;
        grant_ready = 1'b0;
        apply_reset();
        step();
        n_cmp++;
        if (pending !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL mr_pending: pend=%h, want FFFF", pending);
        end
        step();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_onehot !== 16'h0001) begin
            n_bad++;
            $display("FAIL mr_offer: gv=%b grant=%h, want 1/0001", grant_valid, grant_onehot);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (grant_onehot !== 16'h0000 || grant_valid !== 1'b0 || enc_enable !== 1'b0 ||
            pending !== 16'h0000 || drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL mr_async: grant=%h gv=%b en=%b pend=%h drop=%0d, want all 0",
                     grant_onehot, grant_valid, enc_enable, pending, drop_cnt);
        end
        req = 16'h0000;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (grant_valid !== 1'b0 || pending !== 16'h0000) begin
                n_bad++;
                $display("FAIL mr_quiet[%0d]: gv=%b pend=%h, want 0/0000", i, grant_valid, pending);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        req = 16'h0000;
        grant_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_multi_drop();
        test_drop_saturate();
        test_set_wins();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
